bit_serial_adder_core: RTL and testbench
========================================

Name: bit_serial_adder_core

Overview:
- LSB-first bit-serial two's-complement adder: one bit of each operand per clock, one registered sum bit per clock.
- A single carry flip-flop links successive bits; the word boundary is set by the driver (clr to start, last to mark the MSB).
- Used as a minimal-area arithmetic element in serial datapaths and as the reference block for bit-serial timing studies.

Parameters:
- RESET_X, 1'b0, value loaded into x on reset/clr.
- CARRY_INIT, 1'b0, carry value loaded on reset/clr (non-subtract operation).

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge.
- aresetn  input  1  one clock; reset is asynchronous and active-low.
- clr  input  1  synchronous word start: clears carry/outputs, takes priority over en.
- en  input  1  bit-valid; state advances only when en=1.
- a  input  1  current bit of operand A (LSB first).
- b  input  1  current bit of operand B (LSB first).
- last  input  1  qualifies current bit as the MSB (sign bit) of the word.
- x  output  1  registered sum bit.
- cout  output  1  registered carry out of the bit just summed.
- ovf  output  1  registered signed-overflow flag, valid in the cycle after a last bit.

Behaviour:
- Reset (aresetn=0, async): carry=CARRY_INIT, x=RESET_X, cout=0, ovf=0; held while low.
- Posedge, clr=1: same values as reset; a/b/en ignored that cycle.
- Posedge, clr=0, en=1:
  - x <= a^b^carry.
  - carry <= maj(a,b,carry); cout <= the same value.
  - ovf <= last & (carry ^ maj(a,b,carry)), else 0.
- Posedge, clr=0, en=0: all state held; ovf held.
- Latency: bit i driven before posedge k appears on x after posedge k, stable until posedge k+1. Sampling x on the following negedge returns sum bit i.
- Width: unbounded stream. The driver sign-extends operands. N+1 bits sign-extended yield the exact N+1-bit two's-complement sum; higher bits repeat the sign.
- last does not clear carry: a new word requires clr or reset.
- Reset mid-word: word aborted, carry lost; the next word starts fresh after clr/aresetn release.
- Simultaneous clr & en: clr wins.

Optional Feature:
- Macro BIT_SERIAL_ADDER_SUB_EN.
- Defined: adds input sub (1 bit, sampled on the clr cycle and latched for the word). When latched sub=1:
  - b is inverted internally.
  - carry is loaded with 1 on clr.
  - Result is A−B.
  - ovf uses the inverted b.
  - Reset clears the latched sub to 0.
- Undefined: no sub port; behaviour as above (add only).

Test Plan:
- Reset: aresetn=0 mid-stream with carry=1 → x=0, cout=0, ovf=0 immediately (async); after release and clr, 1+1 gives bits 0,1,0 → 2.
- Exhaustive unsigned: all x,y in 0..7, clr then 5 bits LSB-first (en=1) → collected x bits equal x+y (e.g. 7+7 → 01110b = 14).
- Signed negative A: for x in 0..7, y in 0..7, A=−x sign-extended, 32 bits → result == −x+y as int (e.g. −5+3 → 0xFFFFFFFE).
- Signed negative B: A=x, B=−y sign-extended, 32 bits → x−y (e.g. 2+(−7) = −5); ovf=0 at last.
- Overflow/en: 4-bit 0111+0001 with last on bit 3 → sum 1000, ovf=1, cout=0. Inserting en=0 gaps between bits gives an identical result, and x is held during the gaps.
- SUB_EN (macro defined): sub=1 at clr, A=3, B=5, 4 bits → 1110 (−2), ovf=0. A=−8, B=1 → 0111 with ovf=1.

Source files
------------

// File: rtl/bit_serial_adder_core.sv
// bit_serial_adder_core
//   LSB-first bit-serial two's-complement adder. One bit of each operand is
//   consumed per enabled clock. One registered sum bit is produced per enabled
//   clock. A single carry flop links successive bits of a word. The driver
//   frames words: clr starts a word, and last marks the sign bit, which
//   qualifies the overflow flag.
//
//   Optional feature macro: BIT_SERIAL_ADDER_SUB_EN
//     Defining this macro adds the input sub. sub is sampled on the clr cycle
//     and held for the whole word. When it is set, the block computes A-B:
//     b is inverted and the carry is seeded with 1.
//
// Parameters
//   RESET_X     value loaded into x on reset/clr
//   CARRY_INIT  carry value loaded on reset/clr for an add word
//
// Ports
//   clk      rising-edge clock
//   aresetn  asynchronous active-low reset
//   clr      synchronous word start; has priority over en
//   en       bit valid; state only advances when set
//   a, b     current operand bits, LSB first
//   last     current bit is the MSB (sign bit) of the word
//   sub      (macro only) subtract select, sampled on clr
//   x        registered sum bit
//   cout     registered carry out of the bit just summed
//   ovf      registered signed overflow; meaningful after a last bit
module bit_serial_adder_core #(
  parameter logic RESET_X    = 1'b0,
  parameter logic CARRY_INIT = 1'b0
) (
  input  logic clk,
  input  logic aresetn,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic b,
  input  logic last,
`ifdef BIT_SERIAL_ADDER_SUB_EN
  input  logic sub,
`endif
  output logic x,
  output logic cout,
  output logic ovf
);

  logic carry_q;
  logic b_eff;
  logic sum_d;
  logic maj_d;
  logic carry_seed;

`ifdef BIT_SERIAL_ADDER_SUB_EN
  logic sub_q;

  // The subtract mode is latched at word start, so sub may change mid-word
  // without affecting the word that is in flight.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)  sub_q <= 1'b0;
    else if (clr)  sub_q <= sub;
  end

  // A-B is formed as A + ~B + 1. The +1 enters through the carry seed.
  assign b_eff      = b ^ sub_q;
  assign carry_seed = sub ? 1'b1 : CARRY_INIT;
`else
  assign b_eff      = b;
  assign carry_seed = CARRY_INIT;
`endif

  assign sum_d = a ^ b_eff ^ carry_q;
  assign maj_d = (a & b_eff) | (a & carry_q) | (b_eff & carry_q);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      carry_q <= CARRY_INIT;
      x       <= RESET_X;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (clr) begin
      carry_q <= carry_seed;
      x       <= RESET_X;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (en) begin
      carry_q <= maj_d;
      x       <= sum_d;
      cout    <= maj_d;
      // Signed overflow occurs when the carry into the sign bit differs from
      // the carry out of it.
      ovf     <= last & (carry_q ^ maj_d);
    end
  end

endmodule

// File: tb/tb_bit_serial_adder_core.sv
module tb_bit_serial_adder_core;

  logic clk = 1'b0;
  logic aresetn, clr, en, a, b, last;
`ifdef BIT_SERIAL_ADDER_SUB_EN
  logic sub;
`endif
  logic x, cout, ovf;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bit_serial_adder_core dut (
    .clk(clk), .aresetn(aresetn), .clr(clr), .en(en),
    .a(a), .b(b), .last(last),
`ifdef BIT_SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .x(x), .cout(cout), .ovf(ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the edge. Outputs are read 1 time
  // unit after the following edge.
  task automatic step(input logic ai, input logic bi, input logic li, input logic ei,
                      output logic xo);
    a = ai; b = bi; last = li; en = ei;
    @(posedge clk); #1;
    xo = x;
  endtask

  task automatic word_start(input logic s);
`ifdef BIT_SERIAL_ADDER_SUB_EN
    sub = s;
`endif
    clr = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
`ifdef BIT_SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
  endtask

  task automatic run_word(input logic [31:0] av, input logic [31:0] bv, input int n,
                          input logic s, output logic [31:0] r);
    logic xo;
    r = '0;
    word_start(s);
    for (int i = 0; i < n; i++) begin
      step(av[i], bv[i], (i == n - 1), 1'b1, xo);
      r[i] = xo;
    end
  endtask

  initial begin
    logic [31:0] r;
    logic xo;
    aresetn = 1'b0; clr = 1'b0; en = 1'b0; a = 1'b0; b = 1'b0; last = 1'b0;
`ifdef BIT_SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x", {31'b0, x}, 32'd0);
    chk("rst_cout", {31'b0, cout}, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    aresetn = 1'b1;

    // Build up a carry=1 and x=1, then pull the reset asynchronously mid-cycle.
    word_start(1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, xo);
    step(1'b1, 1'b1, 1'b0, 1'b1, xo);
    chk("pre_rst_x", {31'b0, xo}, 32'd1);
    chk("pre_rst_cout", {31'b0, cout}, 32'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("async_x", {31'b0, x}, 32'd0);
    chk("async_cout", {31'b0, cout}, 32'd0);
    chk("async_ovf", {31'b0, ovf}, 32'd0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    run_word(32'd1, 32'd1, 3, 1'b0, r);
    chk("post_rst_1p1", r, 32'd2);

    // clr has priority over en.
    word_start(1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, xo);
    a = 1'b1; b = 1'b1; en = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; en = 1'b0;
    chk("clr_pri_x", {31'b0, x}, 32'd0);
    chk("clr_pri_cout", {31'b0, cout}, 32'd0);

    // Exhaustive unsigned, 5 bits.
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        run_word(32'(i), 32'(j), 5, 1'b0, r);
        chk($sformatf("uns_%0d+%0d", i, j), r & 32'h1f, 32'(i + j));
      end

    // Signed: negative A, then negative B, over 32 bits.
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        run_word(32'(-i), 32'(j), 32, 1'b0, r);
        chk($sformatf("negA_-%0d+%0d", i, j), r, 32'(j - i));
        run_word(32'(i), 32'(-j), 32, 1'b0, r);
        chk($sformatf("negB_%0d-%0d", i, j), r, 32'(i - j));
        chk($sformatf("negB_ovf_%0d_%0d", i, j), {31'b0, ovf}, 32'd0);
      end

    // 4-bit overflow: 0111 + 0001 = 1000 with ovf set.
    run_word(32'd7, 32'd1, 4, 1'b0, r);
    chk("ovf4_sum", r & 32'hf, 32'h8);
    chk("ovf4_ovf", {31'b0, ovf}, 32'd1);
    chk("ovf4_cout", {31'b0, cout}, 32'd0);

    // The same word with en=0 gaps. x and ovf must hold through each gap.
    word_start(1'b0);
    r = '0;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] av, bv;
      av = 4'h7; bv = 4'h1;
      step(av[i], bv[i], (i == 3), 1'b1, xo);
      r[i] = xo;
      step(~av[i], ~bv[i], 1'b1, 1'b0, xo);
      chk($sformatf("gap_hold_x%0d", i), {31'b0, xo}, {31'b0, r[i]});
    end
    chk("gap_sum", r & 32'hf, 32'h8);
    chk("gap_ovf", {31'b0, ovf}, 32'd1);
    chk("gap_cout", {31'b0, cout}, 32'd0);

`ifdef BIT_SERIAL_ADDER_SUB_EN
    run_word(32'd3, 32'd5, 4, 1'b1, r);
    chk("sub_3m5", r & 32'hf, 32'he);
    chk("sub_3m5_ovf", {31'b0, ovf}, 32'd0);
    run_word(32'h8, 32'd1, 4, 1'b1, r);
    chk("sub_m8m1", r & 32'hf, 32'h7);
    chk("sub_m8m1_ovf", {31'b0, ovf}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
